core_dmem_resp: RTL and testbench



---
 rtl/core_dmem_resp.sv | 162 ++++++++++++++++
 tb/tb_core_dmem_resp.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/core_dmem_resp.sv
// Data-memory responder for the RV32I core: word-organised SRAM with configurable
// wait states, lane-checked stores and sign/zero-extended loads.
module core_dmem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        ISLOAD_SS,
    input  logic        ISSTORE_SS,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    input  logic [3:0]  STRB,
    input  logic        ISLOADBS,
    input  logic        ISLOADHWS,
    output logic [31:0] RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_widx;
    logic [1:0]    r_lane;
    logic [31:0]   r_wdata;
    logic [3:0]    r_strb;
    logic          r_is_load;
    logic          r_sbs;
    logic          r_shws;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic          r_done;
    logic          r_err_o;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_req;
    logic          w_lane_ok;
    logic [29:0]   w_word_off;
    logic          w_below;
    logic          w_oor;
    logic          w_reject;
    logic [31:0]   w_rword;
    logic [31:0]   w_rshift;
    logic [31:0]   w_rext;
    logic [31:0]   w_wshift;
    logic          w_wr_en;

    assign w_req = (r_state == S_IDLE) && (ISLOAD_SS || ISSTORE_SS);

    // Lane legality: the mask shape fixes the width, ADDR[1:0] must point at it.
    always_comb begin
        w_lane_ok = 1'b0;
        case (STRB)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_lane_ok = (STRB == (4'b0001 << ADDR[1:0]));
            4'b0011:                            w_lane_ok = (ADDR[1:0] == 2'b00);
            4'b1100:                            w_lane_ok = (ADDR[1:0] == 2'b10);
            4'b1111:                            w_lane_ok = (ADDR[1:0] == 2'b00);
            default:                            w_lane_ok = 1'b0;
        endcase
    end

    // BASE_ADDR is word aligned, so the word offset is a plain subtraction of word indices.
    assign w_word_off = ADDR[31:2] - BASE_ADDR[31:2];
    assign w_below    = (ADDR < BASE_ADDR);
    assign w_oor      = (w_word_off >= 30'(DEPTH_WORDS));
    assign w_reject   = (ISLOAD_SS && ISSTORE_SS) || !w_lane_ok || w_below || w_oor;

    assign BUSY = (r_state != S_IDLE) || ISLOAD_SS || ISSTORE_SS;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_widx    <= '0;
            r_lane    <= 2'd0;
            r_wdata   <= 32'd0;
            r_strb    <= 4'd0;
            r_is_load <= 1'b0;
            r_sbs     <= 1'b0;
            r_shws    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_widx    <= w_word_off[AW-1:0];
                        r_lane    <= ADDR[1:0];
                        r_wdata   <= WDATA;
                        r_strb    <= STRB;
                        r_is_load <= ISLOAD_SS && !ISSTORE_SS;
                        r_sbs     <= ISLOADBS;
                        r_shws    <= ISLOADHWS;
                        r_err     <= w_reject;
                        r_cnt     <= CNT_INIT;
                        r_state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACCESS: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign w_rword  = r_mem[r_widx];
    assign w_rshift = w_rword >> {r_lane, 3'b000};
    assign w_wshift = r_wdata << {r_lane, 3'b000};
    assign w_wr_en  = (r_state == S_ACCESS) && !r_is_load && !r_err;

    always_comb begin
        w_rext = w_rword;
        if (r_strb == 4'b0011 || r_strb == 4'b1100) begin
            w_rext = {{16{r_shws & w_rshift[15]}}, w_rshift[15:0]};
        end else if (r_strb != 4'b1111) begin
            w_rext = {{24{r_sbs & w_rshift[7]}}, w_rshift[7:0]};
        end
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_rdata <= 32'd0;
            r_done  <= 1'b0;
            r_err_o <= 1'b0;
        end else begin
            r_done  <= (r_state == S_ACCESS);
            r_err_o <= (r_state == S_ACCESS) && r_err;
            if (r_state == S_ACCESS && r_is_load) begin
                r_rdata <= r_err ? 32'd0 : w_rext;
            end
        end
    end

    // The array has no reset; only the enabled byte lanes are written.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (r_strb[i]) begin
                    r_mem[r_widx][8*i +: 8] <= w_wshift[8*i +: 8];
                end
            end
        end
    end

    assign RDATA = r_rdata;
    assign DONE  = r_done;
    assign ERR   = r_err_o;
endmodule

// File: tb/tb_core_dmem_resp.sv
// Directed bench for core_dmem_resp: one instance with two wait states and one with
// none, sharing the same request inputs; obs_sel picks whose outputs are observed.
module tb_core_dmem_resp;
  logic        clk = 1'b0;
  logic        nrst;
  logic        isload, isstore, lbs, lhs;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;

  logic [31:0] rdata2, rdata0;
  logic        busy2, busy0, done2, done0, err2, err0;
  logic        obs_sel;
  logic [31:0] o_rdata;
  logic        o_busy, o_done, o_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  core_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut (
    .CLK(clk), .NRST(nrst), .ISLOAD_SS(isload), .ISSTORE_SS(isstore), .ADDR(addr),
    .WDATA(wdata), .STRB(strb), .ISLOADBS(lbs), .ISLOADHWS(lhs),
    .RDATA(rdata2), .BUSY(busy2), .DONE(done2), .ERR(err2)
  );

  core_dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .CLK(clk), .NRST(nrst), .ISLOAD_SS(isload), .ISSTORE_SS(isstore), .ADDR(addr),
    .WDATA(wdata), .STRB(strb), .ISLOADBS(lbs), .ISLOADHWS(lhs),
    .RDATA(rdata0), .BUSY(busy0), .DONE(done0), .ERR(err0)
  );

  assign o_rdata = obs_sel ? rdata0 : rdata2;
  assign o_busy  = obs_sel ? busy0  : busy2;
  assign o_done  = obs_sel ? done0  : done2;
  assign o_err   = obs_sel ? err0   : err2;

  // Presents one request, then counts BUSY cycles until DONE (bounded at 40 cycles).
  task automatic run_acc(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s, input logic b,
                         input logic h, output int lat, output int nb,
                         output logic bz_done, output logic er, output logic [31:0] rd);
    @(posedge clk); #1;
    isload = ld; isstore = st; addr = a; wdata = w; strb = s; lbs = b; lhs = h;
    #1;
    nb = (o_busy === 1'b1) ? 1 : 0;
    lat = -1; bz_done = 1'bx; er = 1'bx; rd = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      isload = 1'b0; isstore = 1'b0;
      #1;
      if (o_done === 1'b1) begin
        lat = k; bz_done = o_busy; er = o_err; rd = o_rdata;
        break;
      end
      if (o_busy === 1'b1) nb++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; isload = 0; isstore = 0; addr = 0; wdata = 0; strb = 0; lbs = 0; lhs = 0;
    obs_sel = 1'b0;
    #3;
    n_cmp++; if (rdata2 !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata2); end
    n_cmp++; if ({busy2, done2, err2} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy2, done2, err2}); end
    n_cmp++; if ({rdata0, busy0, done0, err0} !== 35'd0) begin n_fail++; $display("FAIL reset_dut0 got=%h exp=0", {rdata0, busy0, done0, err0}); end
    isload = 1'b1; #1;
    n_cmp++; if (busy2 !== 1'b1) begin n_fail++; $display("FAIL reset_busy_strobe got=%b exp=1", busy2); end
    isload = 1'b0;
    @(posedge clk); #1 nrst = 1'b1;
  endtask

  task automatic test_word();
    int lat, nb; logic bz, er; logic [31:0] rd;
    obs_sel = 1'b0;
    run_acc(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL word_store_latency got=%0d exp=4", lat); end
    n_cmp++; if (nb !== 4) begin n_fail++; $display("FAIL word_store_busy_cycles got=%0d exp=4", nb); end
    n_cmp++; if ({bz, er} !== 2'b00) begin n_fail++; $display("FAIL word_store_busy_err_at_done got=%b exp=00", {bz, er}); end
    run_acc(1, 0, 32'h10, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL word_load got=%h/%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_extend();
    int lat, nb; logic bz, er; logic [31:0] rd;
    run_acc(1, 0, 32'h13, 32'h0, 4'b1000, 1, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'hFFFFFFDE) begin n_fail++; $display("FAIL byte_signed got=%h exp=ffffffde", rd); end
    run_acc(1, 0, 32'h13, 32'h0, 4'b1000, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'h000000DE) begin n_fail++; $display("FAIL byte_unsigned got=%h exp=000000de", rd); end
    run_acc(1, 0, 32'h10, 32'h0, 4'b0011, 0, 1, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL half_signed got=%h exp=ffffbeef", rd); end
    run_acc(1, 0, 32'h12, 32'h0, 4'b1100, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'h0000DEAD) begin n_fail++; $display("FAIL half_unsigned_upper got=%h exp=0000dead", rd); end
  endtask

  task automatic test_partial();
    int lat, nb; logic bz, er; logic [31:0] rd;
    run_acc(0, 1, 32'h11, 32'h000000A5, 4'b0010, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'h0000DEAD || er !== 1'b0) begin n_fail++; $display("FAIL store_holds_rdata got=%h/%b exp=0000dead/0", rd, er); end
    run_acc(1, 0, 32'h10, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'hDEADA5EF) begin n_fail++; $display("FAIL partial_store got=%h exp=deada5ef", rd); end
  endtask

  task automatic test_reject();
    int lat, nb; logic bz, er; logic [31:0] rd;
    run_acc(0, 1, 32'h11, 32'h0000FFFF, 4'b0011, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (er !== 1'b1 || lat !== 4) begin n_fail++; $display("FAIL misaligned_half err=%b lat=%0d exp=1/4", er, lat); end
    run_acc(1, 0, 32'h10, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'hDEADA5EF || er !== 1'b0) begin n_fail++; $display("FAIL mem_unchanged got=%h/%b exp=deada5ef/0", rd, er); end
    run_acc(1, 0, 32'h1000, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL out_of_range err=%b rd=%h exp=1/0", er, rd); end
    run_acc(1, 1, 32'h10, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL both_strobes err=%b exp=1", er); end
    run_acc(1, 0, 32'h10, 32'h0, 4'b0101, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++; $display("FAIL bad_strb err=%b rd=%h exp=1/0", er, rd); end
    run_acc(1, 0, 32'h10, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL err_clears err=%b exp=0", er); end
  endtask

  task automatic test_back_to_back();
    int lat, nb; logic bz, er; logic [31:0] rd;
    obs_sel = 1'b1;
    @(posedge clk); #1;
    isload = 1; isstore = 0; addr = 32'h10; wdata = 0; strb = 4'b1111; lbs = 0; lhs = 0;
    #1;
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL w0_busy_c0 got=%b exp=1", o_busy); end
    @(posedge clk); #1;
    isload = 0; isstore = 1; wdata = 32'h0; strb = 4'b1111;
    #1;
    n_cmp++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL w0_c1 busy/done=%b%b exp=10", o_busy, o_done); end
    @(posedge clk); #1;
    isstore = 0;
    #1;
    n_cmp++; if (o_done !== 1'b1 || o_busy !== 1'b0 || o_rdata !== 32'hDEADA5EF) begin n_fail++; $display("FAIL w0_c2 done/busy=%b%b rd=%h exp=10/deada5ef", o_done, o_busy, o_rdata); end
    isload = 1; addr = 32'h10; strb = 4'b0001; lbs = 1;
    #1;
    n_cmp++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_c2 got=%b exp=1", o_busy); end
    @(posedge clk); #1;
    isload = 0; lbs = 0;
    #1;
    n_cmp++; if (o_done !== 1'b0 || o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_c3 done/busy=%b%b exp=01", o_done, o_busy); end
    @(posedge clk); #2;
    n_cmp++; if (o_done !== 1'b1 || o_rdata !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL b2b_c4 done=%b rd=%h exp=1/ffffffef", o_done, o_rdata); end
    repeat (6) @(posedge clk);
    obs_sel = 1'b0;
    run_acc(1, 0, 32'h10, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'hDEADA5EF) begin n_fail++; $display("FAIL ignored_store got=%h exp=deada5ef", rd); end
  endtask

  task automatic test_reset_mid();
    int lat, nb; logic bz, er; logic [31:0] rd; int saw_done;
    obs_sel = 1'b0;
    run_acc(0, 1, 32'h20, 32'h12345678, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    run_acc(1, 0, 32'h10, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    @(posedge clk); #1;
    isstore = 1; addr = 32'h20; wdata = 32'hCAFEF00D; strb = 4'b1111;
    @(posedge clk); #1;
    isstore = 0; nrst = 1'b0;
    #1;
    n_cmp++; if ({o_busy, o_done, o_err} !== 3'b000 || o_rdata !== 32'd0) begin n_fail++; $display("FAIL mid_reset_outputs flags=%b rd=%h exp=000/0", {o_busy, o_done, o_err}, o_rdata); end
    @(posedge clk); #1 nrst = 1'b1;
    saw_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #2;
      if (o_done === 1'b1) saw_done++;
    end
    n_cmp++; if (saw_done !== 0) begin n_fail++; $display("FAIL mid_reset_no_done got=%0d exp=0", saw_done); end
    run_acc(1, 0, 32'h20, 32'h0, 4'b1111, 0, 0, lat, nb, bz, er, rd);
    n_cmp++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL mid_reset_no_write got=%h exp=12345678", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_extend();
    test_partial();
    test_reject();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
